// File: rtl/i2c_reg_writer.sv
// Open-drain I2C master: writes {slave addr+W, reg[15:8], reg[7:0]} per transaction,
// paced by a 100 kHz strobe; NACK retries the same latched frame, success pulses register_done.
module i2c_reg_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe_100kHz,
  input  logic        enable,
  input  logic [6:0]  slave_address,
  input  logic [15:0] register_address,
  output logic        register_done,
  input  logic        scl_do,
  output logic        scl_di,
  input  logic        sda_do,
  output logic        sda_di
);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  phase, phase_nxt;
  logic [4:0]  slot, slot_nxt;
  logic [26:0] frame, frame_nxt;
  logic        retry, retry_nxt;
  logic        scl_nxt, sda_nxt, done_nxt;
  logic        ack_slot;

  // Slots 8, 17 and 26 are the slave's ACK bits; master releases SDA there.
  assign ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= 2'd0;
      slot          <= 5'd0;
      frame         <= '0;
      retry         <= 1'b0;
      scl_di        <= 1'b1;
      sda_di        <= 1'b1;
      register_done <= 1'b0;
    end else if (strobe_100kHz) begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      slot          <= slot_nxt;
      frame         <= frame_nxt;
      retry         <= retry_nxt;
      scl_di        <= scl_nxt;
      sda_di        <= sda_nxt;
      register_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    slot_nxt  = slot;
    frame_nxt = frame;
    retry_nxt = retry;
    scl_nxt   = scl_di;
    sda_nxt   = sda_di;
    done_nxt  = register_done;
    case (state)
      IDLE: begin
        scl_nxt  = 1'b1;
        sda_nxt  = 1'b1;
        done_nxt = 1'b0;
        if (enable) begin
          // A retry resends the frame captured for the failed attempt.
          if (!retry)
            frame_nxt = {slave_address, 1'b0, 1'b1, register_address[15:8], 1'b1,
                         register_address[7:0], 1'b1};
          retry_nxt = 1'b0;
          phase_nxt = 2'd0;
          slot_nxt  = 5'd0;
          state_nxt = START;
        end
      end
      START: begin
        if (phase == 2'd0) begin
          sda_nxt   = 1'b0;
          phase_nxt = 2'd1;
        end else begin
          scl_nxt   = 1'b0;
          phase_nxt = 2'd0;
          state_nxt = BITS;
        end
      end
      BITS: begin
        case (phase)
          2'd0: begin
            scl_nxt   = 1'b0;
            sda_nxt   = ack_slot ? 1'b1 : frame[5'd26 - slot];
            phase_nxt = 2'd1;
          end
          2'd1: phase_nxt = 2'd2;
          2'd2: begin
            scl_nxt   = 1'b1;
            phase_nxt = 2'd3;
          end
          default: begin
            // Held here while the slave stretches SCL low.
            if (scl_do) begin
              phase_nxt = 2'd0;
              if (ack_slot && sda_do) begin
                retry_nxt = 1'b1;
                state_nxt = STOP;
              end else if (slot == 5'd26) begin
                state_nxt = STOP;
              end else begin
                slot_nxt = slot + 5'd1;
              end
            end
          end
        endcase
      end
      STOP: begin
        case (phase)
          2'd0: begin
            scl_nxt   = 1'b0;
            sda_nxt   = 1'b0;
            phase_nxt = 2'd1;
          end
          2'd1: begin
            scl_nxt   = 1'b1;
            phase_nxt = 2'd2;
          end
          default: begin
            sda_nxt   = 1'b1;
            phase_nxt = 2'd0;
            done_nxt  = !retry;
            state_nxt = retry ? IDLE : DONE;
          end
        endcase
      end
      DONE: begin
        done_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_writer.sv
// Directed/random bench for i2c_reg_writer: a bus-level slave decodes START/bits/STOP,
// ACKs or NACKs, stretches SCL; expected bytes and tick timing come from transaction arithmetic.
module tb_i2c_reg_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic        en_tb = 1'b0;
  logic        enable;
  logic [6:0]  slave_address = 7'h10;
  logic [15:0] register_address = 16'h0;
  logic        register_done, scl_di, sda_di, scl_do, sda_do;
  logic        stretch = 1'b0;
  logic        slave_low = 1'b0;
  bit          seq_mode = 1'b0;
  int          seq_cnt = 0;
  int          nack_req = 0;
  int          nacks_given = 0;

  int n_chk = 0, n_fail = 0;

  // Bus monitor logs
  int tick_no = 0, div = 0;
  int start_n = 0, stop_n = 0, done_n = 0, bytes_n = 0;
  int start_log[64], stop_log[64], done_log[64];
  logic [7:0] byte_log[64];
  logic       ack_log[64];
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitcnt = 0, byte_idx = 0;
  logic [8:0] shreg = '0;

  assign enable = seq_mode ? (seq_cnt < 3) : en_tb;
  assign scl_do = scl_di & ~stretch;
  assign sda_do = sda_di & ~slave_low;

  i2c_reg_writer dut (
    .clk(clk), .reset(reset), .strobe_100kHz(strobe), .enable(enable),
    .slave_address(slave_address), .register_address(register_address),
    .register_done(register_done), .scl_do(scl_do), .scl_di(scl_di),
    .sda_do(sda_do), .sda_di(sda_di)
  );

  always #5 clk = ~clk;

  // Slave model and strobe generator, evaluated on the inactive edge.
  always @(negedge clk) begin
    logic scl_l, sda_l;
    scl_l = scl_di & ~stretch;
    sda_l = sda_di & ~slave_low;
    if (reset) begin
      slave_low = 1'b0;
    end else if (prev_scl && scl_l && prev_sda && !sda_l) begin
      start_log[start_n] = tick_no; start_n++;
      bitcnt = 0; byte_idx = 0;
    end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
      stop_log[stop_n] = tick_no; stop_n++;
    end else if (!prev_scl && scl_l) begin
      shreg = {shreg[7:0], sda_l};
      bitcnt++;
      if (bitcnt == 9) begin
        byte_log[bytes_n] = shreg[8:1]; ack_log[bytes_n] = shreg[0]; bytes_n++;
        bitcnt = 0; byte_idx++;
      end
    end else if (prev_scl && !scl_l) begin
      if (bitcnt == 8) begin
        if (byte_idx == 0 && nacks_given < nack_req) nacks_given++;
        else slave_low = 1'b1;
      end else begin
        slave_low = 1'b0;
      end
    end
    prev_scl = scl_di & ~stretch;
    prev_sda = sda_di & ~slave_low;
    div    = (div == 3) ? 0 : div + 1;
    strobe = (div == 0);
    if (strobe) begin
      tick_no++;
      if (register_done) begin
        done_log[done_n] = tick_no; done_n++;
        if (seq_mode) seq_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!strobe);
    #1;
  endtask

  task automatic idle_ticks(input string tag, input int n);
    int s0;
    s0 = start_n;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      chk({tag, "_lines"}, {scl_di, sda_di, register_done}, 3'b110);
    end
    chk({tag, "_nostart"}, start_n, s0);
  endtask

  // One transaction; expected timing: done at launch+114 (+5 stretched, +42 per NACKed attempt).
  task automatic run_txn(input string tag, input logic [6:0] sa, input logic [15:0] ra,
                         input bit nack, input bit strch, input int drop_off, input bit scramble);
    int L, exp_done, b_done, b_start, b_bytes, nb, hold_sda;
    logic [7:0] exp_b[4];
    logic       exp_a[4];
    wait_tick();
    slave_address = sa; register_address = ra;
    nack_req = nacks_given + (nack ? 1 : 0);
    b_done = done_n; b_start = start_n; b_bytes = bytes_n;
    en_tb = 1'b1;
    L = tick_no + 1;
    exp_done = L + 114 + (strch ? 5 : 0) + (nack ? 42 : 0);
    hold_sda = 0;
    while (done_n == b_done && tick_no < L + 400) begin
      wait_tick();
      if (tick_no == L + drop_off) en_tb = 1'b0;
      if (scramble && tick_no == L + 5) register_address = 16'($urandom);
      if (strch && tick_no == L + 53) begin stretch = 1'b1; hold_sda = int'(sda_di); end
      if (strch && tick_no == L + 58) begin
        chk({tag, "_stretch_sda"}, sda_di, hold_sda[0]);
        chk({tag, "_stretch_scl"}, scl_di, 1'b1);
        stretch = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, done_n - b_done, 1);
    chk({tag, "_done_tick"}, done_log[b_done] - L, exp_done - L);
    chk({tag, "_starts"}, start_n - b_start, nack ? 2 : 1);
    chk({tag, "_start_tick"}, start_log[b_start] - L, 1);
    chk({tag, "_stop_tick"}, stop_log[stop_n - 1] - L, exp_done - 1 - L);
    nb = 0;
    if (nack) begin exp_b[0] = {sa, 1'b0}; exp_a[0] = 1'b1; nb = 1; end
    exp_b[nb] = {sa, 1'b0}; exp_b[nb+1] = ra[15:8]; exp_b[nb+2] = ra[7:0];
    exp_a[nb] = 1'b0; exp_a[nb+1] = 1'b0; exp_a[nb+2] = 1'b0;
    nb += 3;
    chk({tag, "_nbytes"}, bytes_n - b_bytes, nb);
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_byte"}, byte_log[b_bytes + i], exp_b[i]);
      chk({tag, "_ack"}, ack_log[b_bytes + i], exp_a[i]);
    end
    en_tb = 1'b0;
    idle_ticks({tag, "_after"}, 6);
  endtask

  initial begin
    int L, b_done, b_start;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init", {scl_di, sda_di, register_done}, 3'b110);
    reset = 1'b0;
    idle_ticks("idle0", 5);

    // Basic write
    run_txn("basic", 7'h10, 16'hA53C, 1'b0, 1'b0, 0, 1'b0);
    // NACK on address byte, retried with the same frame
    run_txn("nack", 7'h10, 16'h1234, 1'b1, 1'b0, 42, 1'b0);
    // Clock stretching on byte 2 bit 3
    run_txn("stretch", 7'h2B, 16'hC35A, 1'b0, 1'b1, 0, 1'b0);
    // Enable dropped mid-transaction
    run_txn("endrop", 7'h55, 16'h0FF0, 1'b0, 1'b0, 40, 1'b0);
    // Random words, register_address changed after latch
    for (int k = 0; k < 4; k++)
      run_txn("rand", 7'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 1'b1);

    // Reset mid-BITS
    wait_tick();
    slave_address = 7'h10; register_address = 16'hFFFF; en_tb = 1'b1;
    L = tick_no + 1;
    while (tick_no < L + 20) wait_tick();
    en_tb = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid", {scl_di, sda_di, register_done}, 3'b110);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_ticks("rst_idle", 20);

    // Sequencer: done-qualified counter gates enable
    b_done = done_n; b_start = start_n;
    wait_tick();
    slave_address = 7'h10; register_address = 16'h8001;
    seq_mode = 1'b1;
    L = tick_no;
    while (seq_cnt < 3 && tick_no < L + 500) wait_tick();
    chk("seq_cnt", seq_cnt, 3);
    chk("seq_starts", start_n - b_start, 3);
    chk("seq_dones", done_n - b_done, 3);
    idle_ticks("seq_idle", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_writer.md
Name: i2c_reg_writer

Overview:
- Open-drain I2C master that writes one 16-bit word per transaction to a fixed 7-bit slave: the address byte, then register_address[15:8], then register_address[7:0].
- Sits beside a sequencer that steps through an init table and advances on register_done.
- Drives the bus through open-drain pad buffers: fabric drive value tied to 0, and the controller's drive-control outputs act as tristate enables.
- All bus timing is derived from a single-cycle 100 kHz strobe in the system clock domain.

Parameters:
- None. Slave address is a port.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- strobe_100kHz  in  1  one-clk-wide tick at 100 kHz; state advances only on clk edges where it is 1.
- enable  in  1  start or continue issuing transactions while high.
- slave_address  in  7  7-bit I2C slave address; R/W bit is always 0 (write).
- register_address  in  16  word to send; [15:8] is the first data byte, [7:0] the second.
- register_done  out  1  high for exactly one strobe interval after a successful transaction.
- scl_do  in  1  sampled SCL pad level.
- scl_di  out  1  SCL drive control: 1 releases the line (high via pull-up), 0 pulls it low.
- sda_do  in  1  sampled SDA pad level.
- sda_di  out  1  SDA drive control, same encoding as scl_di.

Behaviour:
- Reset, applied any time including mid-transfer: next clk gives scl_di=1, sda_di=1, register_done=0, state IDLE. Internal counters and shift register clear.
- Tick: a clk edge with strobe_100kHz=1. Outputs change only on ticks, except reset.
- IDLE: both lines released. On a tick with enable=1:
  - latch {slave_address,1'b0, register_address[15:8], register_address[7:0]} into a 27-bit frame with ack slots;
  - go to START.
- START, 2 ticks:
  - tick 1: sda_di=0 with SCL released (START condition);
  - tick 2: scl_di=0.
- BITS: 3 bytes of 8 bits plus an ACK slot each, sent MSB first, 27 bit slots in total. Each slot is 4 ticks:
  - P0: scl_di=0, set sda_di to the bit value; release SDA in ACK slots;
  - P1: hold;
  - P2: release SCL;
  - P3: if scl_do=0 (clock stretching), stay in P3 and sample on each later tick until scl_do=1; otherwise sample sda_do and go to next slot.
- ACK slot: sampled sda_do=0 means ACK, 1 means NACK. Any NACK aborts to STOP with a retry flag set.
- STOP, 3 ticks:
  - tick 1: scl_di=0, sda_di=0;
  - tick 2: scl_di=1;
  - tick 3: sda_di=1.
- After STOP:
  - retry flag set: go to IDLE, no done. The same word is resent on the next eligible tick; the sequencer did not advance.
  - otherwise: go to DONE.
- DONE: register_done=1 from the clk after entry through and including the next tick. On that tick register_done drops and state goes to IDLE. Result: a sequencer qualifying with strobe sees done exactly once per transaction.
- A nominal transaction is 2 + 108 + 3 + 1 = 114 ticks, giving 25 kHz SCL.
- enable dropping mid-transaction does not abort; the transaction completes, done included.
- register_address may change any time; only the value latched at the IDLE to START tick is sent.
- Non-tick clk edges never change outputs or state.

Test Plan:
- Reset: assert reset for 2 clk mid-BITS → next clk gives scl_di=1, sda_di=1, register_done=0. After release with enable=0, lines stay released for 20 ticks.
- Basic write: slave_address=7'h10, register_address=16'hA53C, slave model ACKs all → START, then SDA bytes 0x20, 0xA5, 0x3C sampled at SCL rising edges, then STOP. register_done is high at exactly one tick, 114 ticks after start.
- Sequencer: a counter increments on strobe&register_done while enable=(cnt<3) → exactly 3 transactions, count ends at 3, bus then idle.
- NACK: slave NACKs the address byte → STOP after slot 9, no register_done, identical frame (0x20...) retransmitted.
- Clock stretching: slave holds scl_do=0 for 5 ticks during bit 3 of byte 2 → SDA stays stable and no sample is taken until release. Transaction completes 5 ticks later (119 ticks).
- Enable drop: deassert enable at tick 40 → transaction completes with register_done, then no new START.
